rps_round_judge: RTL and testbench
==================================

# rps_round_judge

Downstream datapath for the arcade round controller. Consumes the controller's level strobes `ld_left`, `ld_right` and `ld_user`. Spins the two CPU symbol reels while their strobes are high and freezes each reel when its strobe drops. Captures the player's switch selection and, when the user-load phase ends, scores the player against both CPU hands and drives saturating scoreboards for the display stage.

## Interface
- `SPIN_DIV`, 4: clock cycles per reel advance, ≥2
- `SCORE_W`, 4: scoreboard width in bits
- `clk`  in  1  system clock
- `resetn`  in  1  synchronous, active-low reset
- `ld_left`  in  1  left reel spins while high (from control)
- `ld_right`  in  1  right reel spins while high (from control)
- `ld_user`  in  1  user selection is sampled while high; a 1→0 transition ends the round
- `user_sel`  in  2  player switches: 0 rock, 1 paper, 2 scissors, 3 invalid
- `left_sym`, `right_sym`  out  2  current reel symbols
- `user_sym`  out  2  captured player symbol
- `res_left`, `res_right`  out  2  player vs each hand: 0 none, 1 win, 2 lose, 3 draw
- `result_valid`  out  1  one-cycle pulse when results and scores update
- `user_score`, `cpu_score`  out  SCORE_W  running scores

## Operation
- Divider `div`:
  - free-running 0..SPIN_DIV-1, wraps to 0.
  - `adv` = (div == SPIN_DIV-1), combinational.
- Reels:
  - on a clock edge with `adv`=1 and `ld_x`=1, `x_sym` advances 0→1→2→0.
  - otherwise `x_sym` holds. The reel is frozen whenever `ld_x`=0.
  - Each reel is independent; simultaneous strobes are legal.
- User capture:
  - each edge with `ld_user`=1 and `user_sel`≠3 loads `user_sym` ← `user_sel`.
  - `user_sel`=3 leaves `user_sym` unchanged.
- Round end:
  - `ld_user_q` is a 1-cycle delayed `ld_user`.
  - `fire` = `ld_user_q` & ~`ld_user`.
- On an edge with `fire`=1:
  - `res_left` ← judge(`user_sym`, `left_sym`); `res_right` ← judge(`user_sym`, `right_sym`).
  - `result_valid` ← 1.
  - `user_score` += number of WINs; `cpu_score` += number of LOSEs. Increment is 0, 1 or 2.
- judge(u, c):
  - u==c → DRAW.
  - (u,c) ∈ {(1,0), (2,1), (0,2)} → WIN.
  - else LOSE.
- Scores saturate at 2^SCORE_W-1. An increment of 2 from max-1 yields max.
- `res_*` hold their values until the next `fire` or reset. `result_valid` is 0 on every non-fire edge.
- A new round starts whenever `ld_user` rises again. There is no limit on rounds.

## Timing
- Reset (`resetn`=0 at an edge) sets: `div`, all syms, `res_*`, scores, `result_valid`, `ld_user_q` to 0.
  - Reset mid-round discards the round: no `result_valid` pulse, scores cleared.
  - With `ld_user` held high across reset release, `ld_user_q` starts at 0, so no spurious fire occurs.
- Latency:
  - `ld_user` sampled low at edge N+1 after high at edge N → `result_valid`, `res_*` and scores visible after edge N+1.
  - Judging uses `user_sym` and reel values as registered before that edge. The final sample is taken on edge N.
- Reel visible change: one cycle after the edge where `adv`&`ld_x` is true.
- First `adv` after reset release occurs at the SPIN_DIV-th edge.

## Structure
- Package `rps_pkg`:
  - symbol constants ROCK=0, PAPER=1, SCISSORS=2, SYM_INVALID=3.
  - result constants RES_NONE=0, RES_WIN=1, RES_LOSE=2, RES_DRAW=3.
  - function `rps_judge(u, c)`.
- Sub-module `rps_reel` (clk, resetn, en, adv → sym[1:0]): mod-3 symbol counter, instantiated twice.
- Divider, capture, edge detect and scoring live in the top module.

## Test plan
- Reset: hold `resetn`=0 for 2 cycles with random inputs → all outputs 0, `result_valid` 0.
- Spin: SPIN_DIV=4, release reset, hold `ld_left`=1 for 8 cycles, `ld_right`=0 → `left_sym`=2, `right_sym`=0. Drop `ld_left` → `left_sym` stays 2 for 20 cycles.
- Judge: force left=ROCK, right=SCISSORS, `ld_user` high 3 cycles with `user_sel`=PAPER, then low → one `result_valid` pulse. Expect `res_left`=WIN, `res_right`=LOSE, `user_score`=1, `cpu_score`=1.
- Invalid switch: `user_sel`=1 for 1 cycle, then 3 for the rest of `ld_user` high → `user_sym`=1 at judge.
- Saturation: SCORE_W=4, left=right=ROCK, user PAPER, 9 rounds → `user_score`=15 (8th round reaches 16 → clamps to 15), `cpu_score`=0.
- Reset mid-round: assert `resetn`=0 while `ld_user`=1, deassert with `ld_user`=0 → no `result_valid`, scores 0.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared symbol/result encodings and the judging rule for the rock-paper-scissors
// round datapath.
package rps_pkg;

  typedef logic [1:0] sym_t;
  typedef logic [1:0] res_t;

  localparam sym_t ROCK        = 2'd0;
  localparam sym_t PAPER       = 2'd1;
  localparam sym_t SCISSORS    = 2'd2;
  localparam sym_t SYM_INVALID = 2'd3;

  localparam res_t RES_NONE = 2'd0;
  localparam res_t RES_WIN  = 2'd1;
  localparam res_t RES_LOSE = 2'd2;
  localparam res_t RES_DRAW = 2'd3;

  // Outcome from the player's point of view (u = player, c = CPU hand).
  function automatic res_t rps_judge(input sym_t u, input sym_t c);
    res_t r;
    if (u == c) begin
      r = RES_DRAW;
    end else if ((u == PAPER    && c == ROCK)  ||
                 (u == SCISSORS && c == PAPER) ||
                 (u == ROCK     && c == SCISSORS)) begin
      r = RES_WIN;
    end else begin
      r = RES_LOSE;
    end
    return r;
  endfunction

endpackage

// File: rtl/rps_reel.sv
// One CPU symbol reel: a mod-3 counter that steps only on divider ticks while
// its load strobe is high, and freezes otherwise.
module rps_reel
  import rps_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic       adv,
  output logic [1:0] sym
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sym <= ROCK;
    end else if (en && adv) begin
      sym <= (sym == SCISSORS) ? ROCK : sym + 2'd1;
    end
  end

endmodule

// File: rtl/rps_round_judge.sv
// Round datapath: spins two CPU reels, captures the player's choice and, when
// the user-load phase ends, judges both hands and updates saturating scores.
module rps_round_judge
  import rps_pkg::*;
#(
  parameter int SPIN_DIV = 4,
  parameter int SCORE_W  = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ld_left,
  input  logic               ld_right,
  input  logic               ld_user,
  input  logic [1:0]         user_sel,
  output logic [1:0]         left_sym,
  output logic [1:0]         right_sym,
  output logic [1:0]         user_sym,
  output logic [1:0]         res_left,
  output logic [1:0]         res_right,
  output logic               result_valid,
  output logic [SCORE_W-1:0] user_score,
  output logic [SCORE_W-1:0] cpu_score
);

  localparam int DIV_W = (SPIN_DIV > 2) ? $clog2(SPIN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SPIN_DIV - 1);
  localparam logic [SCORE_W:0] SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};

  logic [DIV_W-1:0] div;
  logic             adv;
  logic             ld_user_q;
  logic             fire;
  res_t             judge_l;
  res_t             judge_r;
  logic [1:0]       win_cnt;
  logic [1:0]       lose_cnt;
  logic [SCORE_W:0] user_sum;
  logic [SCORE_W:0] cpu_sum;
  logic [SCORE_W:0] user_next;
  logic [SCORE_W:0] cpu_next;

  // Free-running spin divider; adv marks the last count of each period.
  assign adv = (div == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div <= '0;
    end else if (adv) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  rps_reel u_reel_left (
    .clk    (clk),
    .resetn (resetn),
    .en     (ld_left),
    .adv    (adv),
    .sym    (left_sym)
  );

  rps_reel u_reel_right (
    .clk    (clk),
    .resetn (resetn),
    .en     (ld_right),
    .adv    (adv),
    .sym    (right_sym)
  );

  // The invalid switch code never overwrites a previously captured choice.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      user_sym <= ROCK;
    end else if (ld_user && (user_sel != SYM_INVALID)) begin
      user_sym <= user_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ld_user_q <= 1'b0;
    end else begin
      ld_user_q <= ld_user;
    end
  end

  assign fire = ld_user_q & ~ld_user;

  always_comb begin
    judge_l   = rps_judge(user_sym, left_sym);
    judge_r   = rps_judge(user_sym, right_sym);
    win_cnt   = {1'b0, (judge_l == RES_WIN)}  + {1'b0, (judge_r == RES_WIN)};
    lose_cnt  = {1'b0, (judge_l == RES_LOSE)} + {1'b0, (judge_r == RES_LOSE)};
    user_sum  = {1'b0, user_score} + (SCORE_W+1)'(win_cnt);
    cpu_sum   = {1'b0, cpu_score}  + (SCORE_W+1)'(lose_cnt);
    user_next = (user_sum > SCORE_MAX) ? SCORE_MAX : user_sum;
    cpu_next  = (cpu_sum  > SCORE_MAX) ? SCORE_MAX : cpu_sum;
  end

  // result_valid is a one-cycle strobe with no back-pressure: the display stage
  // must take res_* and the scores on the cycle it is high (they also hold after).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      res_left     <= RES_NONE;
      res_right    <= RES_NONE;
      result_valid <= 1'b0;
      user_score   <= '0;
      cpu_score    <= '0;
    end else begin
      result_valid <= fire;
      if (fire) begin
        res_left   <= judge_l;
        res_right  <= judge_r;
        user_score <= user_next[SCORE_W-1:0];
        cpu_score  <= cpu_next[SCORE_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_rps_round_judge.sv
// Directed bench for rps_round_judge: reset, reel spin/freeze, a table of
// judged rounds, invalid-switch capture, score saturation and reset mid-round.
module tb_rps_round_judge;

  localparam int SPIN_DIV = 4;
  localparam int SCORE_W  = 4;
  localparam int SMAX     = (1 << SCORE_W) - 1;

  localparam logic [1:0] R = 2'd0, P = 2'd1, S = 2'd2, INV = 2'd3;
  localparam logic [1:0] WIN = 2'd1, LOSE = 2'd2, DRAW = 2'd3;

  logic               clk = 1'b0;
  logic               resetn;
  logic               ld_left, ld_right, ld_user;
  logic [1:0]         user_sel;
  logic [1:0]         left_sym, right_sym, user_sym, res_left, res_right;
  logic               result_valid;
  logic [SCORE_W-1:0] user_score, cpu_score;

  // clock / reset
  always #5 clk = ~clk;

  rps_round_judge #(.SPIN_DIV(SPIN_DIV), .SCORE_W(SCORE_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ld_left      (ld_left),
    .ld_right     (ld_right),
    .ld_user      (ld_user),
    .user_sel     (user_sel),
    .left_sym     (left_sym),
    .right_sym    (right_sym),
    .user_sym     (user_sym),
    .res_left     (res_left),
    .res_right    (res_right),
    .result_valid (result_valid),
    .user_score   (user_score),
    .cpu_score    (cpu_score)
  );

  typedef struct {
    logic [1:0] usr;
    logic [1:0] lsym;
    logic [1:0] rsym;
    logic [1:0] exp_l;
    logic [1:0] exp_r;
    int         uinc;
    int         cinc;
  } vec_t;

  vec_t vecs[7];

  int n_pass  = 0;
  int n_total = 0;

  // scoreboard: {res_left, res_right, user_score, cpu_score}
  logic [2*2+2*SCORE_W-1:0] exp_q[$];
  int exp_user = 0;
  int exp_cpu  = 0;

  // Reel steering state: where the bench expects the divider and reels to be.
  int m_div = 0, m_left = 0, m_right = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    logic adv;
    @(posedge clk);
    if (!resetn) begin
      m_div = 0; m_left = 0; m_right = 0;
    end else begin
      adv = (m_div == SPIN_DIV - 1);
      if (adv && ld_left)  m_left  = (m_left  == 2) ? 0 : m_left + 1;
      if (adv && ld_right) m_right = (m_right == 2) ? 0 : m_right + 1;
      m_div = adv ? 0 : m_div + 1;
    end
    #1;
  endtask

  function automatic int sat(input int v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  task automatic set_reels(input int l, input int r);
    for (int i = 0; i < 64; i++) begin
      if (m_left == l && m_right == r) break;
      ld_left  = (m_left != l);
      ld_right = (m_right != r);
      tick();
    end
    ld_left = 0; ld_right = 0;
    check("reel_left_pos", left_sym, l);
    check("reel_right_pos", right_sym, r);
  endtask

  task automatic push_exp(input logic [1:0] el, input logic [1:0] er, input int ui, input int ci);
    exp_user = sat(exp_user + ui);
    exp_cpu  = sat(exp_cpu + ci);
    exp_q.push_back({el, er, SCORE_W'(exp_user), SCORE_W'(exp_cpu)});
  endtask

  // Called on the cycle after the fire edge; pops one expected round.
  task automatic check_round(input string tag);
    logic [2*2+2*SCORE_W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_valid"},     result_valid, 1);
    check({tag, "_res_left"},  res_left,  e[2*SCORE_W+3 -: 2]);
    check({tag, "_res_right"}, res_right, e[2*SCORE_W+1 -: 2]);
    check({tag, "_user_score"}, user_score, e[2*SCORE_W-1 -: SCORE_W]);
    check({tag, "_cpu_score"},  cpu_score,  e[SCORE_W-1:0]);
    tick();
    check({tag, "_valid_drop"}, result_valid, 0);
    check({tag, "_res_hold"},   res_left, e[2*SCORE_W+3 -: 2]);
  endtask

  task automatic run_round(input logic [1:0] sel, input logic [1:0] el, input logic [1:0] er,
                           input int ui, input int ci, input string tag);
    ld_left = 0; ld_right = 0;
    ld_user = 1; user_sel = sel;
    repeat (3) begin
      tick();
      check({tag, "_no_early_valid"}, result_valid, 0);
    end
    ld_user = 0; user_sel = 2'($urandom_range(0, 3));
    push_exp(el, er, ui, ci);
    tick();
    check_round(tag);
  endtask

  task automatic do_reset();
    resetn = 0;
    repeat (2) tick();
    resetn = 1;
    exp_user = 0; exp_cpu = 0;
  endtask

  initial begin
    vecs[0] = '{P, R, S, WIN,  LOSE, 1, 1};
    vecs[1] = '{R, R, P, DRAW, LOSE, 0, 1};
    vecs[2] = '{S, P, P, WIN,  WIN,  2, 0};
    vecs[3] = '{R, S, R, WIN,  DRAW, 1, 0};
    vecs[4] = '{S, R, S, LOSE, DRAW, 0, 1};
    vecs[5] = '{P, S, P, LOSE, DRAW, 0, 1};
    vecs[6] = '{R, S, S, WIN,  WIN,  2, 0};

    // reset with random inputs
    resetn = 0;
    ld_left = 0; ld_right = 0; ld_user = 0; user_sel = 0;
    repeat (2) begin
      ld_left  = 1'($urandom_range(0, 1));
      ld_right = 1'($urandom_range(0, 1));
      ld_user  = 1'($urandom_range(0, 1));
      user_sel = 2'($urandom_range(0, 3));
      tick();
    end
    check("rst_left_sym", left_sym, 0);
    check("rst_right_sym", right_sym, 0);
    check("rst_user_sym", user_sym, 0);
    check("rst_res_left", res_left, 0);
    check("rst_res_right", res_right, 0);
    check("rst_valid", result_valid, 0);
    check("rst_user_score", user_score, 0);
    check("rst_cpu_score", cpu_score, 0);

    // spin left for 8 cycles from reset release: adv on edges 4 and 8
    ld_user = 0; ld_right = 0; ld_left = 1; resetn = 1;
    repeat (8) tick();
    check("spin_left", left_sym, 2);
    check("spin_right", right_sym, 0);
    ld_left = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("frozen_left", left_sym, 2);
    end
    check("spin_no_valid", result_valid, 0);

    // table of judged rounds
    for (int i = 0; i < 7; i++) begin
      set_reels(vecs[i].lsym, vecs[i].rsym);
      run_round(vecs[i].usr, vecs[i].exp_l, vecs[i].exp_r, vecs[i].uinc, vecs[i].cinc,
                $sformatf("vec%0d", i));
    end

    // invalid switch: PAPER for one cycle then invalid; PAPER must be judged
    set_reels(R, R);
    ld_user = 1; user_sel = P;
    tick();
    user_sel = INV;
    repeat (3) tick();
    check("inv_user_sym", user_sym, P);
    ld_user = 0;
    push_exp(WIN, WIN, 2, 0);
    tick();
    check("inv_user_sym_judge", user_sym, P);
    check_round("inv");

    // saturation: 9 rounds of two wins each
    ld_user = 0; ld_left = 0; ld_right = 0;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      run_round(P, WIN, WIN, 2, 0, $sformatf("sat%0d", k));
    end
    check("sat_final_user", user_score, SMAX);
    check("sat_final_cpu", cpu_score, 0);

    // reset mid-round, released with ld_user low
    ld_user = 1; user_sel = S;
    repeat (2) tick();
    resetn = 0;
    repeat (2) tick();
    resetn = 1; ld_user = 0;
    exp_user = 0; exp_cpu = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_valid", result_valid, 0);
    end
    check("midrst_user_score", user_score, 0);
    check("midrst_cpu_score", cpu_score, 0);
    check("midrst_user_sym", user_sym, 0);

    // ld_user held high across reset release: no spurious fire
    ld_user = 1; user_sel = P;
    resetn = 0;
    repeat (2) tick();
    resetn = 1;
    repeat (2) begin
      tick();
      check("hold_rel_no_valid", result_valid, 0);
    end
    ld_user = 0;
    push_exp(WIN, WIN, 2, 0);
    tick();
    check_round("hold_rel");

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
